// File: rtl/sum_pkg.sv
// Shared constants and helpers for the chunk-serial arithmetic engines.
// Defaults describe the full-width operand; tops override N and W as needed.
package sum_pkg;

  localparam int N_DEF = 262144;
  localparam int W_DEF = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  localparam int CC_DEF    = N_DEF / W_DEF;
  localparam int CNT_W_DEF = (clog2(CC_DEF) > 0) ? clog2(CC_DEF) : 1;

  typedef logic [CNT_W_DEF-1:0] chunk_idx_t;

endpackage

// File: rtl/sub_chunk_dp.sv
// Combinational W-bit borrow-ripple slice: d = a - b - bin, bout = borrow out.
module sub_chunk_dp #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] d,
  output logic         bout
);

  logic [W:0] diff;

  // Zero-extend to W+1 bits so the top bit of the result is the borrow.
  assign diff = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
  assign d    = diff[W-1:0];
  assign bout = diff[W];

endmodule

// File: rtl/sub_chunked.sv
// Chunk-serial wide subtractor c = a - b, LSB chunk first, with a one-deep
// registered output stage and valid/ready handshakes on both sides.
module sub_chunked
  import sum_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] c,
  output logic         out_last,
  output logic         borrow_out
);

  localparam int CC    = N / W;
  localparam int CNT_W = (clog2(CC) > 0) ? clog2(CC) : 1;

  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t LAST_IDX = cnt_t'(CC - 1);

  cnt_t         cnt_q;
  logic         borrow_q;
  logic [W-1:0] c_q;
  logic         out_valid_q;
  logic         out_last_q;
  logic         borrow_out_q;

  logic         accept;
  logic         is_last;
  logic         bin;
  logic [W-1:0] d;
  logic         bout;

  // Handshake: a transfer happens on a side in any cycle where valid && ready
  // are both high at the rising edge; valid never depends on ready, and the
  // producer holds its data stable until the transfer completes.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready && !clr;
  assign is_last  = (cnt_q == LAST_IDX);
  assign bin      = (cnt_q == '0) ? 1'b0 : borrow_q;

  sub_chunk_dp #(.W(W)) u_dp (
    .a    (a),
    .b    (b),
    .bin  (bin),
    .d    (d),
    .bout (bout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      borrow_q     <= 1'b0;
      c_q          <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      borrow_out_q <= 1'b0;
    end else if (clr) begin
      // Abort wins over any accept this cycle; c is left as-is.
      cnt_q        <= '0;
      borrow_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      borrow_out_q <= 1'b0;
    end else if (accept) begin
      c_q          <= d;
      out_valid_q  <= 1'b1;
      out_last_q   <= is_last;
      borrow_out_q <= is_last ? bout : 1'b0;
      borrow_q     <= is_last ? 1'b0 : bout;
      cnt_q        <= is_last ? '0 : cnt_q + 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_q  <= 1'b0;
    end
  end

  assign out_valid  = out_valid_q;
  assign c          = c_q;
  assign out_last   = out_last_q;
  assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_sub_chunked.sv
// Directed bench for sub_chunked at N=32, W=8: a vector table of whole
// operands plus hand-written stall, abort and async-reset sequences.
module tb_sub_chunked;

  localparam int N  = 32;
  localparam int W  = 8;
  localparam int CC = N / W;

  logic         clk;
  logic         rst;
  logic         clr;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] c;
  logic         out_last;
  logic         borrow_out;

  int n_vec;
  int n_err;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] c;
    logic         bo;
  } vec_t;

  vec_t tbl[8];

  sub_chunked #(.N(N), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .c          (c),
    .out_last   (out_last),
    .borrow_out (borrow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Offer one chunk at the falling edge, let it be taken, check the output.
  task automatic drive_chunk(input logic [W-1:0] ia, input logic [W-1:0] ib,
                             input logic [W-1:0] ec, input logic el,
                             input logic ebo, input string name);
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    a = ia;
    b = ib;
    #1;
    check({name, ".in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    check({name, ".out_valid"}, 32'(out_valid), 32'd1);
    check({name, ".c"}, 32'(c), 32'(ec));
    check({name, ".out_last"}, 32'(out_last), 32'(el));
    if (el) check({name, ".borrow_out"}, 32'(borrow_out), 32'(ebo));
  endtask

  task automatic run_operand(input vec_t v, input string name);
    for (int i = 0; i < CC; i++)
      drive_chunk(v.a[8*i +: 8], v.b[8*i +: 8], v.c[8*i +: 8], (i == CC - 1), v.bo,
                  $sformatf("%s.ch%0d", name, i));
  endtask

  task automatic go_idle(input string name);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check({name, ".drain_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    vec_t v;
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    clr = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;

    tbl[0] = '{a: 32'h0000_0100, b: 32'h0000_0001, c: 32'h0000_00FF, bo: 1'b0};
    tbl[1] = '{a: 32'h0000_0000, b: 32'h0000_0001, c: 32'hFFFF_FFFF, bo: 1'b1};
    tbl[2] = '{a: 32'h0000_0005, b: 32'h0000_0003, c: 32'h0000_0002, bo: 1'b0};
    tbl[3] = '{a: 32'h1234_5678, b: 32'h0FED_CBA9, c: 32'h0246_8ACF, bo: 1'b0};
    tbl[4] = '{a: 32'h8000_0000, b: 32'h0000_0001, c: 32'h7FFF_FFFF, bo: 1'b0};
    tbl[5] = '{a: 32'h0000_0000, b: 32'hFFFF_FFFF, c: 32'h0000_0001, bo: 1'b1};
    tbl[6] = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, c: 32'h0000_0000, bo: 1'b0};
    tbl[7] = '{a: 32'h00FF_00FF, b: 32'h0100_0000, c: 32'hFFFF_00FF, bo: 1'b1};

    #12;
    check("reset.in_ready", 32'(in_ready), 32'd1);
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.c", 32'(c), 32'd0);
    check("reset.out_last", 32'(out_last), 32'd0);
    check("reset.borrow_out", 32'(borrow_out), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Whole table back-to-back: 32 chunks with no bubbles, out_last every 4th.
    for (int i = 0; i < 8; i++)
      run_operand(tbl[i], $sformatf("vec%0d", i));
    go_idle("table");

    // Backpressure after the 2nd chunk of tbl[3]; result must match the no-stall run.
    v = tbl[3];
    drive_chunk(v.a[7:0], v.b[7:0], v.c[7:0], 1'b0, 1'b0, "bp.ch0");
    drive_chunk(v.a[15:8], v.b[15:8], v.c[15:8], 1'b0, 1'b0, "bp.ch1");
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1;
      a = v.a[23:16];
      b = v.b[23:16];
      #1;
      check("bp.stall_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      check("bp.stall_valid", 32'(out_valid), 32'd1);
      check("bp.stall_c", 32'(c), 32'(v.c[15:8]));
      check("bp.stall_last", 32'(out_last), 32'd0);
    end
    drive_chunk(v.a[23:16], v.b[23:16], v.c[23:16], 1'b0, 1'b0, "bp.ch2");
    drive_chunk(v.a[31:24], v.b[31:24], v.c[31:24], 1'b1, v.bo, "bp.ch3");
    go_idle("bp");

    // Abort mid-operand (b > a); the chunk offered with clr is dropped.
    v = '{a: 32'h0000_0001, b: 32'h0000_0005, c: 32'hFFFF_FFFC, bo: 1'b1};
    drive_chunk(v.a[7:0], v.b[7:0], v.c[7:0], 1'b0, 1'b0, "abort.ch0");
    drive_chunk(v.a[15:8], v.b[15:8], v.c[15:8], 1'b0, 1'b0, "abort.ch1");
    @(negedge clk);
    clr = 1'b1;
    a = v.a[23:16];
    b = v.b[23:16];
    @(posedge clk);
    #1;
    check("abort.out_valid", 32'(out_valid), 32'd0);
    check("abort.out_last", 32'(out_last), 32'd0);
    check("abort.borrow_out", 32'(borrow_out), 32'd0);
    @(negedge clk);
    clr = 1'b0;
    in_valid = 1'b0;
    run_operand('{a: 32'h0102_0304, b: 32'h0101_0101, c: 32'h0001_0203, bo: 1'b0}, "post_abort");
    go_idle("post_abort");

    // Asynchronous reset between edges, two chunks into an operand.
    v = tbl[3];
    drive_chunk(v.a[7:0], v.b[7:0], v.c[7:0], 1'b0, 1'b0, "arst.ch0");
    drive_chunk(v.a[15:8], v.b[15:8], v.c[15:8], 1'b0, 1'b0, "arst.ch1");
    #2;
    rst = 1'b0;
    #1;
    check("arst.out_valid", 32'(out_valid), 32'd0);
    check("arst.c", 32'(c), 32'd0);
    check("arst.in_ready", 32'(in_ready), 32'd1);
    check("arst.out_last", 32'(out_last), 32'd0);
    check("arst.borrow_out", 32'(borrow_out), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_operand(tbl[1], "post_arst");
    run_operand(tbl[2], "post_arst2");
    go_idle("post_arst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
